// File: rtl/clock_pkg.sv
// Shared seven-segment patterns (active-high, bit order g..a) and modulus helpers for the BCD counter stages.
package clock_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b000_0000;

  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_pattern = 7'b011_1111;
      4'd1:    seg_pattern = 7'b000_0110;
      4'd2:    seg_pattern = 7'b101_1011;
      4'd3:    seg_pattern = 7'b100_1111;
      4'd4:    seg_pattern = 7'b110_0110;
      4'd5:    seg_pattern = 7'b110_1101;
      4'd6:    seg_pattern = 7'b111_1101;
      4'd7:    seg_pattern = 7'b000_0111;
      4'd8:    seg_pattern = 7'b111_1111;
      4'd9:    seg_pattern = 7'b110_1111;
      default: seg_pattern = SEG_BLANK;
    endcase
  endfunction

  // Top value MODULUS-1 split into BCD digits; evaluated at elaboration time.
  function automatic int unsigned top_tens(input int unsigned modulus);
    top_tens = (modulus - 1) / 10;
  endfunction

  function automatic int unsigned top_ones(input int unsigned modulus);
    top_ones = (modulus - 1) % 10;
  endfunction

endpackage

// File: rtl/bcd_modulo_counter_7seg_seg7.sv
// BCD digit to seven-segment decoder; codes above 9 produce a blank digit.
module seg7_decode
  import clock_pkg::*;
#(
  parameter int SEG_ACT_LO = 1
) (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg_pattern(digit);
    if (SEG_ACT_LO != 0) seg = ~seg;
  end

endmodule

// File: rtl/bcd_modulo_counter_7seg.sv
// Two-digit BCD modulo-N up/down counter with optional prescaler, preset load and 7-seg outputs.
module bcd_modulo_counter_7seg
  import clock_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TICK_HZ    = 1,
  parameter int MODULUS    = 60,
  parameter int EXT_TICK   = 0,
  parameter int BLANK_LZ   = 0,
  parameter int SEG_ACT_LO = 1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       enable,
  input  logic       tick_in,
  input  logic       up_down,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry,
  output logic       step,
  output logic       load_err,
  output logic [6:0] HEX_TENS,
  output logic [6:0] HEX_ONES
);

  localparam logic [3:0] TOP_TENS = 4'(top_tens(MODULUS));
  localparam logic [3:0] TOP_ONES = 4'(top_ones(MODULUS));

  logic       int_tick;
  logic       step_cond;
  logic       at_top;
  logic       at_zero;
  logic       load_ok;
  logic [7:0] load_val;
  logic [3:0] tens_code;

  generate
    if (EXT_TICK == 0) begin : g_prescaler
      localparam int DIV = CLK_HZ / TICK_HZ;
      localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
      logic [CW-1:0] cnt;

      always_ff @(posedge CLOCK_50) begin
        if (reset || load) begin
          cnt <= '0;
        end else if (enable) begin
          if (cnt == CW'(DIV - 1)) cnt <= '0;
          else                     cnt <= cnt + 1'b1;
        end
      end

      assign int_tick = enable && (cnt == CW'(DIV - 1));
    end else begin : g_no_prescaler
      assign int_tick = 1'b0;
    end
  endgenerate

  assign step_cond = (EXT_TICK != 0) ? (tick_in && enable) : int_tick;
  assign at_top    = (tens == TOP_TENS) && (ones == TOP_ONES);
  assign at_zero   = (tens == 4'd0) && (ones == 4'd0);
  assign load_val  = {4'd0, load_tens} * 8'd10 + {4'd0, load_ones};
  assign load_ok   = (load_tens <= 4'd9) && (load_ones <= 4'd9) && (int'(load_val) < MODULUS);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tens     <= '0;
      ones     <= '0;
      carry    <= 1'b0;
      step     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= 1'b0;
      step     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        if (load_ok) begin
          tens <= load_tens;
          ones <= load_ones;
        end else begin
          load_err <= 1'b1;
        end
      end else if (step_cond) begin
        step <= 1'b1;
        if (up_down) begin
          if (at_top) begin
            tens  <= '0;
            ones  <= '0;
            carry <= 1'b1;
          end else if (ones == 4'd9) begin
            ones <= '0;
            tens <= tens + 4'd1;
          end else begin
            ones <= ones + 4'd1;
          end
        end else begin
          if (at_zero) begin
            tens  <= TOP_TENS;
            ones  <= TOP_ONES;
            carry <= 1'b1;
          end else if (ones == 4'd0) begin
            ones <= 4'd9;
            tens <= tens - 4'd1;
          end else begin
            ones <= ones - 4'd1;
          end
        end
      end
    end
  end

  // Leading-zero blanking reuses the decoder's out-of-range blank path.
  assign tens_code = ((BLANK_LZ != 0) && (tens == 4'd0)) ? 4'hF : tens;

  seg7_decode #(.SEG_ACT_LO(SEG_ACT_LO)) u_seg_tens (.digit(tens_code), .seg(HEX_TENS));
  seg7_decode #(.SEG_ACT_LO(SEG_ACT_LO)) u_seg_ones (.digit(ones),      .seg(HEX_ONES));

endmodule
